// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and types for the CPU operand path.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            byp;
    } operand_t;
endpackage

// File: rtl/cpu_operand_bypass.sv
// cpu_operand_bypass: one operand's x0 force, same-edge writeback capture and held-stage update.
module cpu_operand_bypass
    import cpu_pkg::*;
#(
    parameter int W = XLEN,
    parameter int A = AW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s1_sample,
    input  logic         s2_adv,
    input  logic         s2_hold,
    input  logic [A-1:0] rd_addr,
    input  logic [W-1:0] rf_data,
    input  logic         wb_en,
    input  logic [A-1:0] wb_addr,
    input  logic [W-1:0] wb_data,
    output logic [A-1:0] s1_addr,
    output logic [W-1:0] s2_data
);
    logic         byp;
    logic [W-1:0] byp_data;
    logic [W-1:0] s1_data;
    logic [A-1:0] s2_addr;
    logic         hit_rd;
    logic         hit_s1;
    logic         hit_s2;

    assign hit_rd  = wb_en && wb_addr == rd_addr && rd_addr != A'(REG_X0);
    assign hit_s1  = wb_en && wb_addr == s1_addr && s1_addr != A'(REG_X0);
    assign hit_s2  = wb_en && wb_addr == s2_addr && s2_addr != A'(REG_X0);
    // The register file returns pre-write data on read-during-write, so a write on the sampling edge is captured here
    assign s1_data = (s1_addr == A'(REG_X0)) ? '0 : byp ? byp_data : rf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr  <= '0;
            byp      <= 1'b0;
            byp_data <= '0;
            s2_addr  <= '0;
            s2_data  <= '0;
        end else begin
            if (s1_sample) s1_addr <= rd_addr;
            byp <= s1_sample && hit_rd;
            if (s1_sample && hit_rd) byp_data <= wb_data;
            // A write landing on the S1->S2 edge would otherwise be missed by both S1 and S2
            if (s2_adv) begin
                s2_addr <= s1_addr;
                s2_data <= hit_s1 ? wb_data : s1_data;
            end else if (s2_hold && hit_s2) begin
                s2_data <= wb_data;
            end
        end
    end
endmodule

// File: rtl/cpu_operand_fetch.sv
// cpu_operand_fetch: two-stage operand read absorbing register-file latency with writeback forwarding.
module cpu_operand_fetch #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int AW   = cpu_pkg::AW,
    parameter int SBW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1_addr,
    input  logic [AW-1:0]   in_rs2_addr,
    input  logic [SBW-1:0]  in_sb,
    output logic [AW-1:0]   rf_rs1_addr,
    output logic [AW-1:0]   rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [SBW-1:0]  out_sb
);
    logic           s1_valid;
    logic           s2_valid;
    logic           s2_adv;
    logic           s1_stall;
    logic           s1_sample;
    logic           accept;
    logic [SBW-1:0] s1_sb;
    logic [AW-1:0]  s1_rs1;
    logic [AW-1:0]  s1_rs2;

    assign s2_adv      = s1_valid && (!s2_valid || out_ready);
    assign s1_stall    = s1_valid && !s2_adv;
    assign in_ready    = !s1_valid || s2_adv;
    assign accept      = in_valid && in_ready;
    assign s1_sample   = accept || s1_stall;
    // A stalled S1 re-reads its own addresses so the returned data tracks later writes
    assign rf_rs1_addr = s1_stall ? s1_rs1 : in_rs1_addr;
    assign rf_rs2_addr = s1_stall ? s1_rs2 : in_rs2_addr;
    assign out_valid   = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_sb    <= '0;
            out_sb   <= '0;
        end else begin
            s1_valid <= s1_sample;
            s2_valid <= s2_adv || (s2_valid && !out_ready);
            if (accept) s1_sb <= in_sb;
            if (s2_adv) out_sb <= s1_sb;
        end
    end

    cpu_operand_bypass #(.W(XLEN), .A(AW)) u_rs1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .s1_sample (s1_sample),
        .s2_adv    (s2_adv),
        .s2_hold   (s2_valid && !out_ready),
        .rd_addr   (rf_rs1_addr),
        .rf_data   (rf_rs1),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .s1_addr   (s1_rs1),
        .s2_data   (out_rs1)
    );

    cpu_operand_bypass #(.W(XLEN), .A(AW)) u_rs2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .s1_sample (s1_sample),
        .s2_adv    (s2_adv),
        .s2_hold   (s2_valid && !out_ready),
        .rd_addr   (rf_rs2_addr),
        .rf_data   (rf_rs2),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .s1_addr   (s1_rs2),
        .s2_data   (out_rs2)
    );
endmodule

// File: tb/tb_cpu_operand_fetch.sv
// tb_cpu_operand_fetch: scoreboard bench; expected operands are the architectural register values when presented.
module tb_cpu_operand_fetch;
    localparam int XLEN = 32;
    localparam int AW = 5;
    localparam int SBW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid, in_ready, out_valid, out_ready, wb_en;
    logic [AW-1:0]   in_rs1_addr, in_rs2_addr, rf_rs1_addr, rf_rs2_addr, wb_addr;
    logic [SBW-1:0]  in_sb, out_sb;
    logic [XLEN-1:0] rf_rs1, rf_rs2, wb_data, out_rs1, out_rs2;

    always #5 clk = ~clk;

    cpu_operand_fetch #(.XLEN(XLEN), .AW(AW), .SBW(SBW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_sb(in_sb),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_sb(out_sb)
    );

    // Register file: synchronous read, old data on read-during-write; x0 holds junk on purpose
    logic [XLEN-1:0] rf_mem [32];
    logic            rf_load = 1'b1;

    function automatic logic [XLEN-1:0] init_val(int i);
        if (i == 0) return 32'hBAD0;
        if (i == 5) return 32'h1;
        if (i == 7) return 32'h700;
        if (i == 9) return 32'h900;
        return 32'(i * 32'h11);
    endfunction

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
        end else if (wb_en) begin
            rf_mem[wb_addr] <= wb_data;
        end
        rf_rs1 <= rf_mem[rf_rs1_addr];
        rf_rs2 <= rf_mem[rf_rs2_addr];
    end

    function automatic logic [XLEN-1:0] arch_val(logic [AW-1:0] a);
        return (a == 0) ? '0 : rf_mem[a];
    endfunction

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic lat_mode = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [AW-1:0]  rs1;
        logic [AW-1:0]  rs2;
        logic [SBW-1:0] sb;
        int             acc;
    } ent_t;
    ent_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the head entry must be on the outputs every cycle it is valid, with current register values
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() == 0) begin
                chk("idle_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                chk("out_rs1", 64'(out_rs1), 64'(arch_val(q[0].rs1)));
                chk("out_rs2", 64'(out_rs2), 64'(arch_val(q[0].rs2)));
                chk("out_sb", 64'(out_sb), 64'(q[0].sb));
                if (out_ready) begin
                    if (lat_mode) chk("latency", 64'(cyc - q[0].acc), 64'd2);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back('{rs1: in_rs1_addr, rs2: in_rs2_addr, sb: in_sb, acc: cyc});
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [AW-1:0] r1, logic [AW-1:0] r2, logic [SBW-1:0] sb);
        in_valid = v;
        in_rs1_addr = r1;
        in_rs2_addr = r2;
        in_sb = sb;
    endtask

    task automatic wb(logic en, logic [AW-1:0] a, logic [XLEN-1:0] d);
        wb_en = en;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic send(logic [AW-1:0] r1, logic [AW-1:0] r2, logic [SBW-1:0] sb);
        int t = 0;
        drive(1'b1, r1, r2, sb);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                $display("FAIL send_timeout: in_ready stuck at %0d required 1", in_ready);
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        wb_en = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && q.size() != 0; t++) step(1);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        drive(1'b0, '0, '0, '0);
        wb(1'b0, '0, '0);
        out_ready = 1'b0;
        step(3);
        rf_load = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_rs1", 64'(out_rs1), 64'd0);
        chk("rst_out_rs2", 64'(out_rs2), 64'd0);
        chk("rst_out_sb", 64'(out_sb), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(1);

        lat_mode = 1'b1;
        for (int i = 0; i < 4; i++) send(5'd1, 5'd2, 32'h100 + 32'(i));
        in_valid = 1'b0;
        step(4);
        lat_mode = 1'b0;

        wb(1'b1, 5'd5, 32'hDEAD);
        send(5'd5, 5'd1, 32'h200);
        wb(1'b0, '0, '0);
        in_valid = 1'b0;
        step(3);

        wb(1'b1, 5'd0, 32'hFFFF);
        send(5'd0, 5'd0, 32'h300);
        wb(1'b0, '0, '0);
        in_valid = 1'b0;
        step(3);

        out_ready = 1'b0;
        drive(1'b1, 5'd3, 5'd7, 32'h400);
        step(1);
        drive(1'b1, 5'd9, 5'd9, 32'h401);
        step(1);
        drive(1'b1, 5'd4, 5'd6, 32'h402);
        chk("in_ready_full", 64'(in_ready), 64'd0);
        step(1);
        wb(1'b1, 5'd7, 32'h77);
        step(1);
        wb(1'b1, 5'd9, 32'hABC);
        step(1);
        wb(1'b0, '0, '0);
        chk("in_ready_held", 64'(in_ready), 64'd0);
        step(2);
        out_ready = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(4);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom);
            out_ready = $urandom_range(0, 3) != 0;
            wb($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
            step(1);
        end
        drain();

        out_ready = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 32'h500);
        step(1);
        drive(1'b1, 5'd3, 5'd4, 32'h501);
        step(1);
        in_valid = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_rs1", 64'(out_rs1), 64'd0);
        chk("arst_out_sb", 64'(out_sb), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        step(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(5);
        send(5'd2, 5'd1, 32'h600);
        in_valid = 1'b0;
        step(4);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
